divider_top_v1: RTL
===================

# divider_top_v1

Sequential 32-bit integer divider for the RV32M accelerator, covering DIV, DIVU, REM and REMU. It is the inverse-operation companion of the multiplier unit and presents the same start/done handshake to the core. It uses a radix-2 restoring algorithm with one quotient bit per cycle. RISC-V divide-by-zero and signed-overflow results are produced by dedicated fast paths.

## Interface
- Parameters: none. Width is fixed at 32.
- `clk_i` input 1: single clock; all state updates on rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `div_en_i` input 1: start request; sampled only in IDLE.
- `op_A_i` input 32: dividend; captured on the start edge.
- `op_B_i` input 32: divisor; captured on the start edge.
- `signed_i` input 1: 1 selects DIV/REM (two's complement); 0 selects DIVU/REMU. Captured on the start edge.
- `rem_i` input 1: 1 returns the remainder; 0 returns the quotient. Captured on the start edge.
- `result_o` output 32: registered result; held until the next completion.
- `done_o` output 1: one-cycle completion pulse.

## Operation
- The FSM has five states: IDLE, PREP, CALC, FIX, DONE.
- IDLE
  - If `div_en_i`=1: latch operands and control into internal registers, then go to PREP.
  - Otherwise stay in IDLE.
- PREP
  - Compute magnitudes |A| and |B|. Negation applies only when `signed_i`=1 and the operand's MSB is 1.
  - Record sign_q = A[31]^B[31] and sign_r = A[31]. Both are forced to 0 when unsigned.
  - Detect special cases, then go to FIX. Otherwise clear the remainder register, load the dividend shifter, set counter=31 and go to CALC.
  - Divide-by-zero (B==0): quotient = 0xFFFFFFFF, remainder = A.
  - Signed overflow (signed, A==0x80000000, B==0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- CALC (one iteration per cycle)
  - R' = {R[31:0], dividend MSB}, using a 33-bit partial remainder.
  - Compute T = R' − {1'b0,|B|}.
  - If T is non-negative: R=T and shift in quotient bit 1. Otherwise R=R' and shift in quotient bit 0.
  - The dividend shifts left by 1 each cycle.
  - When counter==0, go to FIX. Otherwise decrement the counter.
- FIX
  - Skipped for special cases, which use their preset values.
  - Quotient = sign_q ? −Q : Q. Remainder = sign_r ? −R[31:0] : R[31:0].
  - Load `result_o` with the remainder if `rem_i`, else the quotient. Go to DONE.
- DONE: `done_o`=1, then go to IDLE.
- `div_en_i` asserted in any state other than IDLE is ignored. It is not queued.
- Input operands may change freely after the start edge without affecting the result.

## Timing
- Reset values: `result_o`=0, `done_o`=0, FSM=IDLE, counter=0, all datapath registers 0.
- Normal operation: the start edge is edge 0, PREP→CALC happens at edge 1, and CALC runs edges 2–33. The FIX→DONE transition, where `result_o` is loaded, happens at edge 34. `done_o` is high from edge 34 to edge 35, so latency is 34 cycles.
- Special cases: PREP→FIX at edge 1 and FIX→DONE at edge 2. `done_o` is high from edge 2 to edge 3, so latency is 2 cycles.
- `result_o` changes only on the FIX→DONE edge and is valid while `done_o`=1 and afterwards.
- `div_en_i` held high continuously restarts in the cycle after DONE, giving back-to-back operations with one IDLE cycle between them.
- Reset asserted mid-operation: the FSM returns to IDLE immediately. No `done_o` pulse is generated and `result_o` reads 0.

## Structure
- Shared package `divider_pkg_V1` holds:
  - the state encoding: IDLE=0, PREP=1, CALC=2, FIX=3, DONE=4, in 3 bits;
  - `DIV_WIDTH`=32 and `DIV_ITER`=32;
  - the special-case constants 0xFFFFFFFF and 0x80000000.
- The top holds the FSM and counter. The natural split is one sub-module, `divider_DP_V1`, containing the operand registers, negators, 33-bit subtractor, shifters and the result register.
- The FSM drives the DP through load, step and fix enables.

## Test plan
- DIVU 100/7 → `result_o`=14 after 34 cycles. Same operands with REMU → 2.
- DIV −7/2 (0xFFFFFFF9, 2) → 0xFFFFFFFD. REM → 0xFFFFFFFF.
- DIVU 0x12345678/0 → 0xFFFFFFFF. REMU → 0x12345678. Both complete with 2-cycle latency.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM → 0. Both complete with 2-cycle latency.
- DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF. Pulse `div_en_i` during CALC with different operands → pulse ignored, result unchanged, exactly one `done_o`.
- Start DIV 1000/3, assert `rst_i` at cycle 10 → no `done_o`, `result_o`=0, FSM in IDLE. A new DIVU 9/3 then returns 3.

Source files
------------

// File: rtl/divider_pkg_V1.sv
// Shared definitions for the RV32M sequential divider: FSM encoding,
// datapath widths and the RISC-V special-case result constants.
package divider_pkg_V1;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;

  localparam logic [4:0] DIV_CNT_INIT = 5'(DIV_ITER - 1);

  localparam logic [DIV_WIDTH-1:0] DIV_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [DIV_WIDTH-1:0] DIV_INT_MIN  = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/divider_DP_V1.sv
// Divider datapath: operand capture, magnitude/sign preparation, radix-2
// restoring iteration and final sign correction into the result register.
module divider_DP_V1
  import divider_pkg_V1::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_load,
  input  logic                 i_prep,
  input  logic                 i_step,
  input  logic                 i_fix,
  input  logic [DIV_WIDTH-1:0] i_op_a,
  input  logic [DIV_WIDTH-1:0] i_op_b,
  input  logic                 i_signed,
  input  logic                 i_rem,
  output logic                 o_special,
  output logic [DIV_WIDTH-1:0] o_result
);

  logic [DIV_WIDTH-1:0] r_a;
  logic [DIV_WIDTH-1:0] r_b;
  logic                 r_signed;
  logic                 r_rem_sel;
  logic [DIV_WIDTH-1:0] r_mag_b;
  logic [DIV_WIDTH-1:0] r_dvd;
  logic [DIV_WIDTH-1:0] r_quot;
  logic [DIV_WIDTH-1:0] r_part;
  logic                 r_sign_q;
  logic                 r_sign_r;
  logic [DIV_WIDTH-1:0] r_result;

  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [DIV_WIDTH-1:0] w_abs_a;
  logic [DIV_WIDTH-1:0] w_abs_b;
  logic                 w_div_zero;
  logic                 w_ovf;
  logic [DIV_WIDTH:0]   w_shift;
  logic [DIV_WIDTH:0]   w_trial;
  logic [DIV_WIDTH-1:0] w_q_fix;
  logic [DIV_WIDTH-1:0] w_r_fix;

  assign w_neg_a    = r_signed & r_a[DIV_WIDTH-1];
  assign w_neg_b    = r_signed & r_b[DIV_WIDTH-1];
  assign w_abs_a    = w_neg_a ? -r_a : r_a;
  assign w_abs_b    = w_neg_b ? -r_b : r_b;
  assign w_div_zero = (r_b == '0);
  assign w_ovf      = r_signed && (r_a == DIV_INT_MIN) && (r_b == DIV_ALL_ONES);
  assign o_special  = w_div_zero | w_ovf;

  // Partial remainder stays below |B| after every step, so 32 stored bits suffice.
  assign w_shift = {r_part, r_dvd[DIV_WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_mag_b};

  assign w_q_fix = r_sign_q ? -r_quot : r_quot;
  assign w_r_fix = r_sign_r ? -r_part : r_part;

  assign o_result = r_result;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a       <= '0;
      r_b       <= '0;
      r_signed  <= 1'b0;
      r_rem_sel <= 1'b0;
      r_mag_b   <= '0;
      r_dvd     <= '0;
      r_quot    <= '0;
      r_part    <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_result  <= '0;
    end else begin
      if (i_load) begin
        r_a       <= i_op_a;
        r_b       <= i_op_b;
        r_signed  <= i_signed;
        r_rem_sel <= i_rem;
      end
      if (i_prep) begin
        // Special cases preload final values with signs cleared so FIX passes them through.
        if (w_div_zero) begin
          r_quot   <= DIV_ALL_ONES;
          r_part   <= r_a;
          r_sign_q <= 1'b0;
          r_sign_r <= 1'b0;
        end else if (w_ovf) begin
          r_quot   <= DIV_INT_MIN;
          r_part   <= '0;
          r_sign_q <= 1'b0;
          r_sign_r <= 1'b0;
        end else begin
          r_mag_b  <= w_abs_b;
          r_dvd    <= w_abs_a;
          r_quot   <= '0;
          r_part   <= '0;
          r_sign_q <= w_neg_a ^ w_neg_b;
          r_sign_r <= w_neg_a;
        end
      end
      if (i_step) begin
        r_dvd <= {r_dvd[DIV_WIDTH-2:0], 1'b0};
        if (!w_trial[DIV_WIDTH]) begin
          r_part <= w_trial[DIV_WIDTH-1:0];
          r_quot <= {r_quot[DIV_WIDTH-2:0], 1'b1};
        end else begin
          r_part <= w_shift[DIV_WIDTH-1:0];
          r_quot <= {r_quot[DIV_WIDTH-2:0], 1'b0};
        end
      end
      if (i_fix) begin
        r_result <= r_rem_sel ? w_r_fix : w_q_fix;
      end
    end
  end

endmodule

// File: rtl/divider_top_v1.sv
// RV32M divider top: start/done handshake FSM and iteration counter driving
// the datapath through load, prep, step and fix enables.
module divider_top_v1
  import divider_pkg_V1::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 div_en_i,
  input  logic [DIV_WIDTH-1:0] op_A_i,
  input  logic [DIV_WIDTH-1:0] op_B_i,
  input  logic                 signed_i,
  input  logic                 rem_i,
  output logic [DIV_WIDTH-1:0] result_o,
  output logic                 done_o
);

  div_state_e r_state;
  logic [4:0] r_cnt;
  logic       r_done;

  logic w_load;
  logic w_prep;
  logic w_step;
  logic w_fix;
  logic w_special;

  assign w_load = (r_state == ST_IDLE) && div_en_i;
  assign w_prep = (r_state == ST_PREP);
  assign w_step = (r_state == ST_CALC);
  assign w_fix  = (r_state == ST_FIX);
  assign done_o = r_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (div_en_i) r_state <= ST_PREP;
        end
        ST_PREP: begin
          if (w_special) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt   <= DIV_CNT_INIT;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (r_cnt == 5'd0) r_state <= ST_FIX;
          else               r_cnt   <= r_cnt - 5'd1;
        end
        ST_FIX: begin
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  divider_DP_V1 u_dp (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_load    (w_load),
    .i_prep    (w_prep),
    .i_step    (w_step),
    .i_fix     (w_fix),
    .i_op_a    (op_A_i),
    .i_op_b    (op_B_i),
    .i_signed  (signed_i),
    .i_rem     (rem_i),
    .o_special (w_special),
    .o_result  (result_o)
  );

endmodule
